// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with overlap control, input qualification,
// synchronous clear and registered match copy. Define SEQDET_MATCH_CNT_EN to add match_cnt.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                FW      = $clog2(PAT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  // in is sampled only when in_valid=1; there is no back-pressure, every valid bit is consumed.
  input  logic             in_valid,
  input  logic             in,
  input  logic             clr,
  output logic             q,
  output logic             q_reg,
  output logic [FW-1:0]    fill
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_MIN = FW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] h;
  logic [PAT_LEN-1:0] h_next;
  logic [PAT_LEN-1:0] w;
  logic [FW-1:0]      fill_next;
  logic               hit;

  assign w = {h[PAT_LEN-2:0], in};

  // Fill qualification keeps reset zeros from matching an all-zero pattern.
  assign hit = in_valid & ~clr & (fill >= FILL_MIN) & (w == PATTERN);
  assign q   = hit;

  always_comb begin
    h_next    = h;
    fill_next = fill;
    if (clr) begin
      h_next    = '0;
      fill_next = '0;
    end else if (in_valid) begin
      if (hit && !OVERLAP) begin
        h_next    = '0;
        fill_next = '0;
      end else begin
        h_next    = w;
        fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h     <= '0;
      fill  <= '0;
      q_reg <= 1'b0;
    end else begin
      h     <= h_next;
      fill  <= fill_next;
      q_reg <= hit;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= '0;
    end else if (clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param: four pattern/overlap variants share one
// stimulus bus; SEQDET_MATCH_CNT_EN adds a CNT_W=2 instance for the saturating counter.
module tb_seq_detector_param;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       din;
  logic       clr;
  logic       q_w   [4];
  logic       qr_w  [4];
  logic [2:0] fill_w[4];

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  // 0: 1100 overlap, 1: 1010 overlap, 2: 1010 non-overlap, 3: 0000 overlap
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1100), .OVERLAP(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(din), .clr(clr),
    .q(q_w[0]), .q_reg(qr_w[0]), .fill(fill_w[0])
`ifdef SEQDET_MATCH_CNT_EN
    , .match_cnt()
`endif
  );
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(din), .clr(clr),
    .q(q_w[1]), .q_reg(qr_w[1]), .fill(fill_w[1])
`ifdef SEQDET_MATCH_CNT_EN
    , .match_cnt()
`endif
  );
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(din), .clr(clr),
    .q(q_w[2]), .q_reg(qr_w[2]), .fill(fill_w[2])
`ifdef SEQDET_MATCH_CNT_EN
    , .match_cnt()
`endif
  );
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1)) u_d (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(din), .clr(clr),
    .q(q_w[3]), .q_reg(qr_w[3]), .fill(fill_w[3])
`ifdef SEQDET_MATCH_CNT_EN
    , .match_cnt()
`endif
  );

`ifdef SEQDET_MATCH_CNT_EN
  logic       q_e;
  logic       qr_e;
  logic [2:0] fill_e;
  logic [1:0] cnt_e;
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1100), .OVERLAP(1'b1), .CNT_W(2)) u_e (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(din), .clr(clr),
    .q(q_e), .q_reg(qr_e), .fill(fill_e), .match_cnt(cnt_e)
  );
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_rst;
    int         dut;
    logic       v;
    logic       b;
    logic       c;
    logic       eq;
    logic [2:0] ef;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: called at posedge+1
  task automatic do_reset(input int d);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    din      = 1'b0;
    clr      = 1'b0;
    #2;
    chk("rst_fill", 32'(fill_w[d]), 0);
    chk("rst_q", 32'(q_w[d]), 0);
    chk("rst_qreg", 32'(qr_w[d]), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic step(input int d, input logic v, input logic b, input logic c,
                      input logic eq, input logic [2:0] ef);
    in_valid = v;
    din      = b;
    clr      = c;
    #4;
    chk("q", 32'(q_w[d]), 32'(eq));
    exp_q.push_back(eq);
    @(posedge clk);
    #1;
    chk("fill", 32'(fill_w[d]), 32'(ef));
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL q_reg: scoreboard empty");
    end else begin
      chk("q_reg", 32'(qr_w[d]), 32'(exp_q.pop_front()));
    end
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  function automatic void add(input int d, input logic v, input logic b, input logic c,
                              input logic eq, input logic [2:0] ef);
    vec_t e;
    e.is_rst = 1'b0; e.dut = d; e.v = v; e.b = b; e.c = c; e.eq = eq; e.ef = ef;
    vt.push_back(e);
  endfunction

  function automatic void add_rst(input int d);
    vec_t e;
    e.is_rst = 1'b1; e.dut = d; e.v = 0; e.b = 0; e.c = 0; e.eq = 0; e.ef = 0;
    vt.push_back(e);
  endfunction

  initial begin
    reset_n  = 1'b1;
    in_valid = 1'b0;
    din      = 1'b0;
    clr      = 1'b0;

    // 1100 overlap: hits on bits 4 and 8
    add_rst(0);
    add(0,1,1,0,0,1); add(0,1,1,0,0,2); add(0,1,0,0,0,3); add(0,1,0,0,1,4);
    add(0,1,1,0,0,4); add(0,1,1,0,0,4); add(0,1,0,0,0,4); add(0,1,0,0,1,4);
    // 1010 overlap: hits on bits 4, 6, 8
    add_rst(1);
    add(1,1,1,0,0,1); add(1,1,0,0,0,2); add(1,1,1,0,0,3); add(1,1,0,0,1,4);
    add(1,1,1,0,0,4); add(1,1,0,0,1,4); add(1,1,1,0,0,4); add(1,1,0,0,1,4);
    // 1010 non-overlap: hits on bits 4, 8; fill restarts
    add_rst(2);
    add(2,1,1,0,0,1); add(2,1,0,0,0,2); add(2,1,1,0,0,3); add(2,1,0,0,1,0);
    add(2,1,1,0,0,1); add(2,1,0,0,0,2); add(2,1,1,0,0,3); add(2,1,0,0,1,0);
    // 1100 with an invalid gap, in toggling during the gap
    add_rst(0);
    add(0,1,1,0,0,1); add(0,1,1,0,0,2);
    add(0,0,0,0,0,2); add(0,0,1,0,0,2); add(0,0,0,0,0,2);
    add(0,1,0,0,0,3); add(0,1,0,0,1,4);
    // clr beats a completing bit
    add_rst(0);
    add(0,1,1,0,0,1); add(0,1,1,0,0,2); add(0,1,0,0,0,3);
    add(0,1,0,1,0,0); add(0,1,0,0,0,1);
    // clr with in_valid low
    add(0,1,1,0,0,2); add(0,0,0,1,0,0);
    // all-zero pattern: no hit on reset zeros
    add_rst(3);
    add(3,1,0,0,0,1); add(3,1,0,0,0,2); add(3,1,0,0,0,3); add(3,1,0,0,1,4);
    add(3,1,0,0,1,4); add(3,1,1,0,0,4);

    @(posedge clk);
    #1;
    foreach (vt[i]) begin
      if (vt[i].is_rst) do_reset(vt[i].dut);
      else step(vt[i].dut, vt[i].v, vt[i].b, vt[i].c, vt[i].eq, vt[i].ef);
    end

    // reset mid-pattern discards history; restart needs four fresh bits
    do_reset(0);
    step(0,1,1,0,0,1); step(0,1,1,0,0,2); step(0,1,0,0,0,3);
    do_reset(0);
    step(0,1,0,0,0,1);
    step(0,1,1,0,0,2); step(0,1,1,0,0,3); step(0,1,0,0,0,4); step(0,1,0,0,1,4);

    // asynchronous reset seen mid-cycle without a clock edge
    step(0,1,1,0,0,4);
    in_valid = 1'b1;
    din      = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_fill", 32'(fill_w[0]), 0);
    chk("async_q", 32'(q_w[0]), 0);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();

`ifdef SEQDET_MATCH_CNT_EN
    do_reset(0);
    chk("cnt_rst", 32'(cnt_e), 0);
    for (int k = 0; k < 5; k++) begin
      step(0,1,1,0,0,(k == 0) ? 3'd1 : 3'd4);
      step(0,1,1,0,0,(k == 0) ? 3'd2 : 3'd4);
      step(0,1,0,0,0,(k == 0) ? 3'd3 : 3'd4);
      step(0,1,0,0,1,4);
      chk("match_cnt", 32'(cnt_e), (k < 3) ? k + 1 : 3);
    end
    step(0,0,0,1,0,0);
    chk("cnt_clr", 32'(cnt_e), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
